sort_loader: RTL and testbench



---
 rtl/sort_pkg.sv | 9 +
 rtl/sort_loader_if.sv | 28 ++
 rtl/sort_loader.sv | 100 ++++++++++
 tb/tb_sort_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and types for the five-input sorter and its loader.
package sort_pkg;
    localparam int NUM_W     = 6;
    localparam int FRAME_LEN = 5;

    typedef logic [NUM_W-1:0] num_t;

    typedef enum logic {FILL, HOLD} loader_state_e;
endpackage

// File: rtl/sort_loader_if.sv
// Serial number input and parallel frame output of the sort loader.
interface sort_loader_if;
    import sort_pkg::*;

    logic in_valid;
    num_t in_data;
    logic in_ready;
    logic in_clear;
    logic out_valid;
    logic out_ready;
    num_t out_num0;
    num_t out_num1;
    num_t out_num2;
    num_t out_num3;
    num_t out_num4;

    modport master (
        output in_valid, in_data, in_clear, out_ready,
        input  in_ready, out_valid,
        input  out_num0, out_num1, out_num2, out_num3, out_num4
    );

    modport slave (
        input  in_valid, in_data, in_clear, out_ready,
        output in_ready, out_valid,
        output out_num0, out_num1, out_num2, out_num3, out_num4
    );
endinterface

// File: rtl/sort_loader.sv
// Groups a serial 6-bit stream into registered 5-number frames for the sorter, held until accepted.
// Optional delivered-frame counter port frame_cnt is built when SORT_LOADER_CNT_EN is defined.
module sort_loader
    import sort_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    sort_loader_if.slave bus
`ifdef SORT_LOADER_CNT_EN
    ,
    output logic [7:0]   frame_cnt
`endif
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    loader_state_e state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    num_t          slots [FRAME_LEN];
    logic          slot_wr;
    logic          in_ready_int;
    logic          out_valid_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // in_clear overrides every transfer and release, in both states.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        slot_wr       = 1'b0;
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        case (state)
            FILL: begin
                in_ready_int = 1'b1;
                if (bus.in_clear) begin
                    idx_nxt = '0;
                end else if (bus.in_valid) begin
                    slot_wr = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            HOLD: begin
                out_valid_int = 1'b1;
                if (bus.in_clear || bus.out_ready) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = FILL;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FRAME_LEN; i++) slots[i] <= '0;
        end else begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                if (slot_wr && idx == 3'(i)) slots[i] <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_num0  = slots[0];
    assign bus.out_num1  = slots[1];
    assign bus.out_num2  = slots[2];
    assign bus.out_num3  = slots[3];
    assign bus.out_num4  = slots[4];

`ifdef SORT_LOADER_CNT_EN
    // A frame dropped by in_clear is never counted as delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (out_valid_int && bus.out_ready && !bus.in_clear) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    idx_in_range: assert property (@(posedge clk) disable iff (!rst_n) idx <= LAST_IDX);

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader with a frame scoreboard; checks via immediate assertions.
module tb_sort_loader;
    import sort_pkg::*;

    typedef logic [4:0][5:0] frame_t;

    logic clk;
    logic rst_n;
`ifdef SORT_LOADER_CNT_EN
    logic [7:0] frame_cnt;
`endif

    sort_loader_if bus();

    sort_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SORT_LOADER_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    frame_t exp_q[$];

    function automatic frame_t mk(input int a, input int b, input int c, input int d, input int e);
        frame_t f;
        f[0] = 6'(a); f[1] = 6'(b); f[2] = 6'(c); f[3] = 6'(d); f[4] = 6'(e);
        return f;
    endfunction

    function automatic frame_t cur_frame();
        frame_t f;
        f[0] = bus.out_num0; f[1] = bus.out_num1; f[2] = bus.out_num2;
        f[3] = bus.out_num3; f[4] = bus.out_num4;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp_v);
`ifdef SORT_LOADER_CNT_EN
        chk(tag, 32'(frame_cnt), 32'(exp_v));
`endif
    endtask

    task automatic chk_slots(input string tag, input frame_t e);
        frame_t o;
        o = cur_frame();
        for (int i = 0; i < 5; i++) chk($sformatf("%s_slot%0d", tag, i), 32'(o[i]), 32'(e[i]));
    endtask

    task automatic chk_frame(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_sb: observed frame with empty scoreboard, expected none", tag);
        end else begin
            chk_slots(tag, exp_q.pop_front());
        end
    endtask

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send(input int n);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'(n);
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < 5; i++) send(int'(f[i]));
        bus.in_valid = 1'b0;
    endtask

    task automatic release_frame();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int k, seen, t1, t2, cyc, nfr;
        logic prev_ov;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_clear  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_slots("rst", mk(0, 0, 0, 0, 0));
        chk_cnt("rst_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame held while the consumer stalls; in_valid during HOLD must be ignored.
        exp_q.push_back(mk(12, 5, 63, 0, 7));
        send_frame(mk(12, 5, 63, 0, 7));
        chk("a_out_valid", 32'(bus.out_valid), 32'd1);
        chk("a_in_ready", 32'(bus.in_ready), 32'd0);
        chk_frame("a");
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd33;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("a_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        chk_slots("a_hold", mk(12, 5, 63, 0, 7));
        bus.in_valid = 1'b0;
        release_frame();
        chk("a_rel_valid", 32'(bus.out_valid), 32'd0);
        chk("a_rel_ready", 32'(bus.in_ready), 32'd1);
        chk_cnt("a_cnt", 1);

        // Back-to-back with in_valid and out_ready high.
        exp_q.push_back(mk(1, 2, 3, 4, 5));
        exp_q.push_back(mk(6, 7, 8, 9, 10));
        bus.out_ready = 1'b1;
        k = 0; seen = 0; t1 = 0; t2 = 0; cyc = 0; prev_ov = 1'b0;
        while (seen < 2 && cyc < 40) begin
            if (prev_ov) begin
                chk("b2b_rel_valid", 32'(bus.out_valid), 32'd0);
                chk("b2b_rel_ready", 32'(bus.in_ready), 32'd1);
            end
            if (bus.out_valid) begin
                chk_frame("b2b");
                seen++;
                if (seen == 1) t1 = cyc; else t2 = cyc;
            end
            prev_ov = bus.out_valid;
            bus.in_valid = (k < 10);
            bus.in_data  = 6'(k + 1);
            if (bus.in_ready && k < 10) k++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_seen", 32'(seen), 32'd2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd6);
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk_cnt("b2b_cnt", 3);

        // Partial frame discarded by in_clear, including the same-cycle datum.
        send(9); send(8); send(7);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd50;
        bus.in_clear = 1'b1;
        @(negedge clk);
        bus.in_clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_ready", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(mk(1, 2, 3, 4, 5));
        send_frame(mk(1, 2, 3, 4, 5));
        chk("clr_frame_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("clr");
        release_frame();
        chk_cnt("clr_cnt", 4);

        // in_clear beats out_ready in HOLD; frame is dropped, not counted, slots kept.
        exp_q.push_back(mk(20, 21, 22, 23, 24));
        send_frame(mk(20, 21, 22, 23, 24));
        chk("hc_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("hc");
        bus.in_clear  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_clear  = 1'b0;
        bus.out_ready = 1'b0;
        chk("hc_drop_valid", 32'(bus.out_valid), 32'd0);
        chk("hc_drop_ready", 32'(bus.in_ready), 32'd1);
        chk("hc_slot0_kept", 32'(bus.out_num0), 32'd20);
        chk_cnt("hc_cnt", 4);
        @(negedge clk);
        chk("hc_no_phantom", 32'(bus.out_valid), 32'd0);

        // 252 more accepted frames take the counter from 4 through 255 to 0.
        bus.out_ready = 1'b1;
        nfr = 0; cyc = 0;
        while (nfr < 252 && cyc < 3000) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 6'(cyc);
            if (bus.out_valid) begin
                if (nfr == 251) chk_cnt("wrap_255", 255);
                nfr++;
                if (nfr == 252) bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("wrap_frames", 32'(nfr), 32'd252);
        chk_cnt("wrap_0", 0);
        chk("wrap_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-frame, checked before any further clock edge.
        send(30); send(31); send(32);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_slots("arst", mk(0, 0, 0, 0, 0));
        chk_cnt("arst_cnt", 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(mk(40, 41, 42, 43, 44));
        send_frame(mk(40, 41, 42, 43, 44));
        chk("post_valid", 32'(bus.out_valid), 32'd1);
        chk_frame("post");
        release_frame();
        chk_cnt("post_cnt", 1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
